// File: rtl/watch_timer_core.sv
`default_nettype none
// ============================================================================
//  Module   : watch_timer_core
//  Brief    : Synchronous mm:ss.mmm BCD up/down timer with prescaler and
//             lap-capture FIFO feeding the display buffer.
//  Revision : 1.0
// ============================================================================
module watch_timer_core #(
  parameter int CLK_PER_MS   = 1,
  parameter int MIN_TENS_MAX = 5,
  parameter int LAP_DEPTH    = 4
) (
  input  logic        clk_1Khz,
  input  logic        rst,
  input  logic        EN,
  input  logic        load,
  input  logic [27:0] preset,
  input  logic        dir,
  input  logic        lap,
  input  logic        lap_rd,
  input  logic        lap_clr,
  input  logic        disp_sel,
  output logic [27:0] time_bcd,
  output logic [23:0] dispbuf,
  output logic [27:0] lap_data,
  output logic        lap_empty,
  output logic        lap_full,
  output logic        lap_ovf,
  output logic        wrap,
  output logic        done
);

  localparam int c_PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int c_AW    = $clog2(LAP_DEPTH);

  function automatic logic [3:0] f_lim(input int idx);
    if (idx == 6)      return 4'(MIN_TENS_MAX);
    else if (idx == 4) return 4'd5;
    else               return 4'd9;
  endfunction

  // ---------------------------------------------------------------- time base
  logic [c_PRE_W-1:0] r_presc;
  logic [6:0][3:0]    r_dig;
  logic               r_wrap;
  logic               r_done;

  logic               w_tick;
  logic [6:0][3:0]    w_dig_up;
  logic [6:0][3:0]    w_dig_dn;
  logic [6:0][3:0]    w_dig_ld;
  logic               w_all_max;
  logic               w_is_zero;
  logic               w_upper_zero;

  // With a single-cycle period the prescaler sits at 0, so tick follows EN.
  assign w_tick = EN && (r_presc == c_PRE_W'(CLK_PER_MS - 1));

  always_comb begin
    logic carry;
    logic borrow;
    carry        = 1'b1;
    borrow       = 1'b1;
    w_all_max    = 1'b1;
    w_is_zero    = 1'b1;
    w_upper_zero = 1'b1;
    w_dig_up     = r_dig;
    w_dig_dn     = r_dig;
    w_dig_ld     = '0;
    for (int i = 0; i < 7; i++) begin
      if (carry)
        w_dig_up[i] = (r_dig[i] >= f_lim(i)) ? 4'd0 : r_dig[i] + 4'd1;
      if (borrow)
        w_dig_dn[i] = (r_dig[i] == 4'd0) ? f_lim(i) : r_dig[i] - 4'd1;
      carry     = carry && (r_dig[i] >= f_lim(i));
      borrow    = borrow && (r_dig[i] == 4'd0);
      w_all_max = w_all_max && (r_dig[i] == f_lim(i));
      w_is_zero = w_is_zero && (r_dig[i] == 4'd0);
      if (i > 0)
        w_upper_zero = w_upper_zero && (r_dig[i] == 4'd0);
      w_dig_ld[i] = (preset[4*i +: 4] > f_lim(i)) ? f_lim(i) : preset[4*i +: 4];
    end
  end

  always_ff @(posedge clk_1Khz or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_dig   <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      if (load) begin
        r_dig   <= w_dig_ld;
        r_presc <= '0;
      end else if (EN) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          if (!dir) begin
            r_dig  <= w_dig_up;
            r_wrap <= w_all_max;
          end else if (!w_is_zero) begin
            // Down-count parks at zero; done fires only on the 1 -> 0 step.
            r_dig  <= w_dig_dn;
            r_done <= w_upper_zero && (r_dig[0] == 4'd1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- lap FIFO
  logic [27:0]     r_mem [LAP_DEPTH];
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW:0]   r_cnt;
  logic            r_empty;
  logic            r_full;
  logic            r_ovf;

  logic            w_pop;
  logic            w_push;
  logic [c_AW:0]   w_cnt_nxt;

  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign w_pop     = lap_rd && !r_empty && !lap_clr;
  assign w_push    = lap && !lap_clr && (!r_full || w_pop);
  assign w_cnt_nxt = r_cnt + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);

  always_ff @(posedge clk_1Khz or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (lap_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == (c_AW+1)'(LAP_DEPTH));
      if (lap && r_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_1Khz) begin
    if (w_push)
      r_mem[r_wr_ptr] <= r_dig;
  end

  // ---------------------------------------------------------------- outputs
  assign time_bcd  = r_dig;
  assign wrap      = r_wrap;
  assign done      = r_done;
  assign lap_data  = r_empty ? '0 : r_mem[r_rd_ptr];
  assign lap_empty = r_empty;
  assign lap_full  = r_full;
  assign lap_ovf   = r_ovf;
  assign dispbuf   = disp_sel ? lap_data[27:4] : time_bcd[27:4];

endmodule
`default_nettype wire

// File: tb/tb_watch_timer_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_watch_timer_core
//  Brief    : Vector, corner-sequence and randomized checks of watch_timer_core
//             against a millisecond-count reference model.
//  Revision : 1.0
// ============================================================================
module tb_watch_timer_core;

  localparam int MTM   = 5;
  localparam int DEPTH = 4;
  localparam int FS    = (MTM*10 + 9)*60000 + 59999;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, EN, load, dir, lap, lap_rd, lap_clr, disp_sel;
  logic [27:0] preset;

  logic [27:0] a_time, a_lap_data, b_time, b_lap_data;
  logic [23:0] a_disp, b_disp;
  logic        a_empty, a_full, a_ovf, a_wrap, a_done;
  logic        b_empty, b_full, b_ovf, b_wrap, b_done;

  watch_timer_core #(.CLK_PER_MS(1), .MIN_TENS_MAX(MTM), .LAP_DEPTH(DEPTH)) u_dut1 (
    .clk_1Khz(clk), .rst(rst), .EN(EN), .load(load), .preset(preset), .dir(dir),
    .lap(lap), .lap_rd(lap_rd), .lap_clr(lap_clr), .disp_sel(disp_sel),
    .time_bcd(a_time), .dispbuf(a_disp), .lap_data(a_lap_data), .lap_empty(a_empty),
    .lap_full(a_full), .lap_ovf(a_ovf), .wrap(a_wrap), .done(a_done));

  watch_timer_core #(.CLK_PER_MS(4), .MIN_TENS_MAX(MTM), .LAP_DEPTH(DEPTH)) u_dut4 (
    .clk_1Khz(clk), .rst(rst), .EN(EN), .load(load), .preset(preset), .dir(dir),
    .lap(lap), .lap_rd(lap_rd), .lap_clr(lap_clr), .disp_sel(disp_sel),
    .time_bcd(b_time), .dispbuf(b_disp), .lap_data(b_lap_data), .lap_empty(b_empty),
    .lap_full(b_full), .lap_ovf(b_ovf), .wrap(b_wrap), .done(b_done));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // -------------------------------------------------- reference model helpers
  function automatic int lim(input int i);
    if (i == 6) return MTM;
    if (i == 4) return 5;
    return 9;
  endfunction

  function automatic int b2ms(input logic [27:0] b);
    int d[7];
    for (int i = 0; i < 7; i++) begin
      d[i] = int'(b[4*i +: 4]);
      if (d[i] > lim(i)) d[i] = lim(i);
    end
    return ((d[6]*10 + d[5])*60 + d[4]*10 + d[3])*1000 + d[2]*100 + d[1]*10 + d[0];
  endfunction

  function automatic logic [27:0] ms2b(input int t);
    int ms, s, m;
    ms = t % 1000;
    s  = (t / 1000) % 60;
    m  = t / 60000;
    return {4'(m/10), 4'(m%10), 4'(s/10), 4'(s%10), 4'(ms/100), 4'((ms/10)%10), 4'(ms%10)};
  endfunction

  int          m_t[2], m_pc[2];
  bit          m_wrap[2], m_done[2];
  bit          m_ovf;
  logic [27:0] q[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_pc[i] = 0; m_wrap[i] = 0; m_done[i] = 0;
    end
    m_ovf = 0;
    q.delete();
  endtask

  task automatic step_inst(input int i, input int cpm);
    m_wrap[i] = 0;
    m_done[i] = 0;
    if (load) begin
      m_t[i]  = b2ms(preset);
      m_pc[i] = 0;
    end else if (EN) begin
      if (m_pc[i] == cpm - 1) begin
        m_pc[i] = 0;
        if (!dir) begin
          if (m_t[i] == FS) begin m_t[i] = 0; m_wrap[i] = 1; end
          else m_t[i]++;
        end else if (m_t[i] != 0) begin
          m_t[i]--;
          if (m_t[i] == 0) m_done[i] = 1;
        end
      end else begin
        m_pc[i]++;
      end
    end
  endtask

  task automatic model_step();
    logic [27:0] cap;
    cap = ms2b(m_t[0]);
    if (lap_clr) begin
      q.delete();
      m_ovf = 0;
    end else begin
      if (lap_rd && q.size() > 0) void'(q.pop_front());
      if (lap) begin
        if (q.size() < DEPTH) q.push_back(cap);
        else m_ovf = 1;
      end
    end
    step_inst(0, 1);
    step_inst(1, 4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // -------------------------------------------------- directed load vectors
  typedef struct {
    logic [27:0] preset;
    logic        dir;
    logic [27:0] exp_ld;
    logic [27:0] exp_tk;
    logic        exp_wrap;
    logic        exp_done;
  } vec_t;

  vec_t vecs[7];

  logic [27:0] tk[5];

  initial begin
    vecs[0] = '{28'h5959998, 1'b0, 28'h5959998, 28'h5959999, 1'b0, 1'b0};
    vecs[1] = '{28'hFFFFFFF, 1'b0, 28'h5959999, 28'h0000000, 1'b1, 1'b0};
    vecs[2] = '{28'h0000003, 1'b1, 28'h0000003, 28'h0000002, 1'b0, 1'b0};
    vecs[3] = '{28'h1000000, 1'b1, 28'h1000000, 28'h0959999, 1'b0, 1'b0};
    vecs[4] = '{28'h0000000, 1'b1, 28'h0000000, 28'h0000000, 1'b0, 1'b0};
    vecs[5] = '{28'h0070000, 1'b0, 28'h0050000, 28'h0050001, 1'b0, 1'b0};
    vecs[6] = '{28'h0000001, 1'b1, 28'h0000001, 28'h0000000, 1'b0, 1'b1};

    rst = 1'b0; EN = 1'b0; load = 1'b0; preset = '0; dir = 1'b0;
    lap = 1'b0; lap_rd = 1'b0; lap_clr = 1'b0; disp_sel = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_time", a_time, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_wrap_done", {a_wrap, a_done}, 0);
    chk("rst_lap_data", a_lap_data, 0);
    chk("rst_disp", a_disp, 0);
    rst = 1'b1;

    // Free-run 1000 clocks, then freeze
    EN = 1'b1;
    repeat (1000) @(negedge clk);
    chk("run1000_time", a_time, 28'h0001000);
    chk("run1000_disp", a_disp, 24'h000100);
    chk("run1000_pre4", b_time, 28'h0000250);
    EN = 1'b0;
    repeat (50) @(negedge clk);
    chk("hold_time", a_time, 28'h0001000);
    chk("hold_pre4", b_time, 28'h0000250);

    // Load vectors: value after load, then after one tick
    foreach (vecs[k]) begin
      load = 1'b1; preset = vecs[k].preset; dir = vecs[k].dir; EN = 1'b0;
      @(negedge clk);
      load = 1'b0;
      chk($sformatf("vec%0d_load", k), a_time, vecs[k].exp_ld);
      EN = 1'b1;
      @(negedge clk);
      EN = 1'b0;
      chk($sformatf("vec%0d_tick", k), a_time, vecs[k].exp_tk);
      chk($sformatf("vec%0d_wrap", k), a_wrap, vecs[k].exp_wrap);
      chk($sformatf("vec%0d_done", k), a_done, vecs[k].exp_done);
    end

    // Wrap pulse is exactly one cycle
    load = 1'b1; preset = 28'h5959998; dir = 1'b0;
    @(negedge clk);
    load = 1'b0; EN = 1'b1;
    @(negedge clk);
    chk("wrap_seq_a", {a_wrap, a_time}, {1'b0, 28'h5959999});
    @(negedge clk);
    chk("wrap_seq_b", {a_wrap, a_time}, {1'b1, 28'h0000000});
    @(negedge clk);
    chk("wrap_seq_c", {a_wrap, a_time}, {1'b0, 28'h0000001});

    // Down to zero, done once, then hold
    EN = 1'b0; load = 1'b1; preset = 28'h0000003; dir = 1'b1;
    @(negedge clk);
    load = 1'b0; EN = 1'b1;
    @(negedge clk);
    chk("down_2", {a_done, a_time}, {1'b0, 28'h2});
    @(negedge clk);
    chk("down_1", {a_done, a_time}, {1'b0, 28'h1});
    @(negedge clk);
    chk("down_0", {a_done, a_time}, {1'b1, 28'h0});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("down_hold", {a_done, a_time}, {1'b0, 28'h0});
    end
    EN = 1'b0; dir = 1'b0;

    // Prescaler of 4
    do_reset();
    EN = 1'b1;
    repeat (40) @(negedge clk);
    chk("pre4_40clk", b_time, 28'h0000010);
    repeat (2) @(negedge clk);
    load = 1'b1; preset = 28'h0000100;
    @(negedge clk);
    load = 1'b0;
    chk("pre4_load", b_time, 28'h0000100);
    repeat (3) @(negedge clk);
    chk("pre4_3clk", b_time, 28'h0000100);
    @(negedge clk);
    chk("pre4_4clk", b_time, 28'h0000101);
    EN = 1'b0;

    // Lap FIFO fill, overflow, ordered drain, clear
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tk[k] = 28'h0111111 * 28'(k + 1);
      load = 1'b1; preset = tk[k];
      @(negedge clk);
      load = 1'b0; lap = 1'b1;
      @(negedge clk);
      lap = 1'b0;
      if (k == 0) chk("lap_head_first", {a_empty, a_lap_data}, {1'b0, tk[0]});
      if (k == 3) chk("lap_full4", {a_full, a_ovf}, 2'b10);
      if (k == 4) chk("lap_ovf5", {a_full, a_ovf}, 2'b11);
    end
    disp_sel = 1'b1;
    #1;
    chk("disp_lap", a_disp, tk[0][27:4]);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lap_pop%0d", k), a_lap_data, tk[k]);
      lap_rd = 1'b1;
      @(negedge clk);
      lap_rd = 1'b0;
    end
    chk("lap_drained", {a_empty, a_full, a_ovf}, 3'b101);
    chk("lap_data_empty", a_lap_data, 0);
    lap_clr = 1'b1;
    @(negedge clk);
    lap_clr = 1'b0; disp_sel = 1'b0;
    chk("lap_clr_ovf", a_ovf, 0);

    // Asynchronous reset between edges
    do_reset();
    EN = 1'b1; lap = 1'b1;
    repeat (2) @(negedge clk);
    lap = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_time", a_time, 0);
    chk("arst_fifo", {a_empty, a_full, a_lap_data}, {1'b1, 1'b0, 28'h0});
    chk("arst_pre4", b_time, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_resume", a_time, 28'h3);
    EN = 1'b0;

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      logic [27:0] hd;
      hd = (q.size() > 0) ? q[0] : 28'h0;
      chk("rnd_time", a_time, ms2b(m_t[0]));
      chk("rnd_wrap_done", {a_wrap, a_done}, {m_wrap[0], m_done[0]});
      chk("rnd_lap_data", a_lap_data, hd);
      chk("rnd_flags", {a_empty, a_full, a_ovf},
          {q.size() == 0, q.size() == DEPTH, m_ovf});
      chk("rnd_disp", a_disp, disp_sel ? hd[27:4] : ms2b(m_t[0]) >> 4);
      chk("rnd_pre4", {b_wrap, b_done, b_time}, {m_wrap[1], m_done[1], ms2b(m_t[1])});

      EN       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      lap      = ($urandom_range(0, 5) == 0);
      lap_rd   = ($urandom_range(0, 4) == 0);
      lap_clr  = ($urandom_range(0, 99) == 0);
      disp_sel = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       preset = 28'($urandom);
        1:       preset = ms2b(FS - int'($urandom_range(0, 5)));
        2:       preset = ms2b(int'($urandom_range(0, 5)));
        default: preset = ms2b(int'($urandom_range(0, FS)));
      endcase
      model_step();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
